// File: rtl/tx_line_buf_pkg.sv
// tx_line_buf_pkg: shared types and constants for the line-buffered UART
// transmit stage (tx_line_buf and its FIFO, txb_fifo).
package tx_line_buf_pkg;

  // Drain sequencer states. EOL_CR/EOL_LF are reachable only when the
  // TXBUF_CRLF_EN build option is defined in tx_line_buf.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    GAP    = 3'd2,
    EOL_CR = 3'd3,
    EOL_LF = 3'd4
  } txbState_t;

  // Line terminator bytes appended to every drain pass in the CRLF build.
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Strobe byte for a terminator state; the byte is irrelevant elsewhere.
  function automatic logic [7:0] eolByte(input txbState_t st);
    return (st == EOL_CR) ? ASCII_CR : ASCII_LF;
  endfunction

endpackage

// File: rtl/txb_fifo.sv
// txb_fifo: DEPTH x 8 circular byte buffer for tx_line_buf.
// The caller only asserts pop when the buffer is non-empty and only asserts
// push when there is room (or a pop in the same cycle frees one), so this
// block does no guarding of its own. level is a true occupancy count,
// 0..DEPTH, one bit wider than the pointers.
module txb_fifo #(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    pushData,
  input  logic          pop,
  output logic [7:0]    headData,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LEVEL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;

  // Byte storage: written at the tail on every accepted push.
  // NOTE: the storage array has no reset; its contents are unreachable until
  // written because count gates every read, and leaving it unreset lets it
  // map onto plain RAM. Sequential state everywhere uses non-blocking
  // assignments so every flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is 2^AW.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + LEVEL_ONE;
        2'b01:   count <= count - LEVEL_ONE;
        default: count <= count;
      endcase
    end
  end

  assign headData = mem[rdPtr];
  assign level    = count;
  assign full     = (count == FULL_LEVEL);
  assign empty    = (count == '0);

endmodule

// File: rtl/tx_line_buf.sv
// tx_line_buf: line-buffered UART transmit stage behind the stream cipher.
// Every cipher byte is captured into txb_fifo. A print_buf pulse in IDLE
// starts a drain pass that sends one byte per strobe to the UART, with one
// mandatory idle (GAP) cycle after each strobe. The pass ends when the FIFO
// is seen empty in DRAIN; bytes arriving mid-pass join the same pass.
//
// Build option TXBUF_CRLF_EN: when defined, every pass is terminated with
// CR (0x0D) then LF (0x0A), including a pass started on an empty FIFO.
// When undefined, the terminator states are not built.
module tx_line_buf
  import tx_line_buf_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_data_rdy,
  input  logic [7:0]    wr_data,
  input  logic          print_buf,
  input  logic          tx_busy,
  output logic          tx_data_rdy,
  output logic [7:0]    tx_data,
  output logic          buf_empty,
  output logic          buf_full,
  output logic          overflow,
  output logic [AW:0]   level
);

  txbState_t  state;
  txbState_t  nextState;
  txbState_t  retState;   // where GAP goes once its idle cycle is over
  txbState_t  nextRet;

  logic       popNow;
  logic       pushNow;
  logic       dropNow;
  logic       sendNow;
  logic [7:0] sendByte;

  logic [7:0] headData;
  logic       fifoFull;
  logic       fifoEmpty;

  txb_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pushNow),
    .pushData (wr_data),
    .pop      (popNow),
    .headData (headData),
    .level    (level),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // State register, including the GAP return target.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      retState <= IDLE;
    end else begin
      state    <= nextState;
      retState <= nextRet;
    end
  end

  // Next-state logic: sequence a drain pass and remember GAP's successor.
  // NOTE: every signal assigned here gets a default on the first lines, so
  // no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    nextRet   = retState;
    case (state)
      IDLE: begin
        if (print_buf) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (fifoEmpty) begin
`ifdef TXBUF_CRLF_EN
          nextState = EOL_CR;
`else
          nextState = IDLE;
`endif
        end else if (!tx_busy) begin
          nextState = GAP;
          nextRet   = DRAIN;
        end
      end
      GAP: begin
        nextState = retState;
      end
`ifdef TXBUF_CRLF_EN
      EOL_CR: begin
        if (!tx_busy) begin
          nextState = GAP;
          nextRet   = EOL_LF;
        end
      end
      EOL_LF: begin
        if (!tx_busy) begin
          nextState = GAP;
          nextRet   = IDLE;
        end
      end
`endif
      default: begin
        nextState = IDLE;
        nextRet   = IDLE;
      end
    endcase
  end

  // Output decode: which byte (if any) to strobe this cycle, FIFO pop/push.
  always_comb begin
    popNow   = 1'b0;
    sendNow  = 1'b0;
    sendByte = headData;
    case (state)
      DRAIN: begin
        if (!fifoEmpty && !tx_busy) begin
          popNow  = 1'b1;
          sendNow = 1'b1;
        end
      end
`ifdef TXBUF_CRLF_EN
      EOL_CR, EOL_LF: begin
        if (!tx_busy) begin
          sendNow  = 1'b1;
          sendByte = eolByte(state);
        end
      end
`endif
      default: begin
        sendNow = 1'b0;
      end
    endcase
    // A write into a full buffer still lands when this cycle's pop frees
    // the head slot; otherwise the byte is lost and flagged.
    pushNow = wr_data_rdy && (!fifoFull || popNow);
    dropNow = wr_data_rdy && !pushNow;
  end

  // Registered UART strobe; tx_data holds the last byte between strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_data_rdy <= 1'b0;
      tx_data     <= 8'h00;
    end else begin
      tx_data_rdy <= sendNow;
      if (sendNow) begin
        tx_data <= sendByte;
      end
    end
  end

  // Sticky overflow: set by a dropped byte, cleared when a pass is started.
  // A drop in the same cycle as the clearing print_buf wins, since that
  // byte is genuinely lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (dropNow) begin
      overflow <= 1'b1;
    end else if ((state == IDLE) && print_buf) begin
      overflow <= 1'b0;
    end
  end

  assign buf_empty = fifoEmpty;
  assign buf_full  = fifoFull;

endmodule

// File: tb/tb_tx_line_buf.sv
// tb_tx_line_buf: scoreboard bench for tx_line_buf. Stimulus pushes expected
// UART bytes into expQ; an independent monitor pops and compares on every
// tx_data_rdy strobe. Builds with or without TXBUF_CRLF_EN.
module tb_tx_line_buf;
  import tx_line_buf_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);
`ifdef TXBUF_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif
  localparam int EOL_N = CRLF ? 2 : 0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_data_rdy = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          print_buf = 1'b0;
  logic          tx_busy = 1'b0;
  logic          tx_data_rdy;
  logic [7:0]    tx_data;
  logic          buf_empty;
  logic          buf_full;
  logic          overflow;
  logic [AW:0]   level;

  tx_line_buf #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data_rdy (wr_data_rdy),
    .wr_data     (wr_data),
    .print_buf   (print_buf),
    .tx_busy     (tx_busy),
    .tx_data_rdy (tx_data_rdy),
    .tx_data     (tx_data),
    .buf_empty   (buf_empty),
    .buf_full    (buf_full),
    .overflow    (overflow),
    .level       (level)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  expQ[$];      // bytes the UART must see, in order
  logic [7:0]  modelBuf[$];  // bytes held in the buffer awaiting a print
  logic        modelOvf = 1'b0;
  int          strobeCyc[$];
  int          strobeCount = 0;
  int          cyc = 0;
  int          printCyc = 0;
  logic        prevRdy = 1'b0;
  logic        busyAtEdge = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    busyAtEdge <= tx_busy;
  end

  // Monitor: every strobe is checked against the scoreboard head.
  always @(negedge clk) begin
    if (tx_data_rdy === 1'b1) begin
      strobeCount++;
      strobeCyc.push_back(cyc);
      check("strobe_back_to_back", 32'(prevRdy), 0);
      check("strobe_while_busy", 32'(busyAtEdge), 0);
      check("strobe_expected", 32'(expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        check("tx_data", 32'(tx_data), 32'(expQ.pop_front()));
      end
    end
    prevRdy = tx_data_rdy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one byte while no pass is active; model decides keep or drop.
  task automatic pushByte(input logic [7:0] b);
    wr_data_rdy = 1'b1;
    wr_data     = b;
    if (modelBuf.size() < DEPTH) modelBuf.push_back(b);
    else modelOvf = 1'b1;
    tick();
    wr_data_rdy = 1'b0;
  endtask

  // Everything buffered goes out in the next pass, then the terminator.
  task automatic queuePass(input bit withEol);
    while (modelBuf.size() > 0) expQ.push_back(modelBuf.pop_front());
    if (withEol && CRLF) begin
      expQ.push_back(ASCII_CR);
      expQ.push_back(ASCII_LF);
    end
  endtask

  task automatic printBuf();
    print_buf = 1'b1;
    modelOvf  = 1'b0;
    tick();
    print_buf = 1'b0;
    printCyc  = cyc;
  endtask

  task automatic waitDrain(input int bound, input bit randBusy);
    for (int i = 0; i < bound && expQ.size() != 0; i++) begin
      if (randBusy) tx_busy = 1'($urandom_range(0, 1));
      tick();
    end
    tx_busy = 1'b0;
    check("drain_complete_left", 32'(expQ.size()), 0);
    expQ.delete();
    repeat (6) tick();
    check("after_drain_level", 32'(level), 0);
    check("after_drain_empty", 32'(buf_empty), 1);
  endtask

  task automatic waitStrobes(input int target, input int bound);
    for (int i = 0; i < bound && strobeCount < target; i++) begin
      @(posedge clk);
      #2;
    end
    check("strobe_wait", 32'(strobeCount >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int n;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    check("rst_tx_data_rdy", 32'(tx_data_rdy), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_buf_empty", 32'(buf_empty), 1);
    check("rst_buf_full", 32'(buf_full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_level", 32'(level), 0);

    // Basic pass: three bytes, exact latency and 2-cycle spacing
    strobeCyc.delete();
    pushByte(8'h41);
    pushByte(8'h42);
    pushByte(8'h43);
    check("t1_level", 32'(level), 3);
    check("t1_empty", 32'(buf_empty), 0);
    queuePass(1'b1);
    printBuf();
    waitDrain(100, 1'b0);
    check("t1_strobe_count", 32'(strobeCyc.size()), 32'(3 + EOL_N));
    if (strobeCyc.size() >= 3) begin
      check("t1_first_latency", 32'(strobeCyc[0] - printCyc), 1);
      check("t1_spacing_1", 32'(strobeCyc[1] - strobeCyc[0]), 2);
      check("t1_spacing_2", 32'(strobeCyc[2] - strobeCyc[1]), 2);
    end

    // Fill to DEPTH, one extra byte is dropped
    for (int i = 0; i < DEPTH; i++) pushByte(8'($urandom_range(0, 255)));
    check("t2_level_full", 32'(level), DEPTH);
    check("t2_full", 32'(buf_full), 1);
    check("t2_no_overflow_yet", 32'(overflow), 32'(modelOvf));
    pushByte(8'h5A);
    check("t2_overflow", 32'(overflow), 32'(modelOvf));
    check("t2_level_after_drop", 32'(level), 32'(modelBuf.size()));
    queuePass(1'b1);
    printBuf();
    check("t2_overflow_cleared", 32'(overflow), 32'(modelOvf));
    waitDrain(400, 1'b0);

    // Busy held 10 cycles before every strobe
    for (int i = 0; i < 4; i++) pushByte(8'($urandom_range(0, 255)));
    queuePass(1'b1);
    start   = strobeCount;
    tx_busy = 1'b1;
    printBuf();
    for (int k = 0; k < 4 + EOL_N; k++) begin
      repeat (10) tick();
      check("t3_held_by_busy", 32'(strobeCount), 32'(start + k));
      tx_busy = 1'b0;
      waitStrobes(start + k + 1, 20);
      tx_busy = 1'b1;
    end
    tx_busy = 1'b0;
    waitDrain(50, 1'b0);

    // Bytes written during a pass join it; one terminator at the end
    for (int i = 0; i < 3; i++) pushByte(8'($urandom_range(0, 255)));
    queuePass(1'b0);
    print_buf   = 1'b1;
    wr_data_rdy = 1'b1;
    b = 8'($urandom_range(0, 255));
    wr_data = b;
    expQ.push_back(b);
    tick();
    print_buf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      wr_data = b;
      expQ.push_back(b);
      tick();
    end
    wr_data_rdy = 1'b0;
    if (CRLF) begin
      expQ.push_back(ASCII_CR);
      expQ.push_back(ASCII_LF);
    end
    waitDrain(100, 1'b0);

    // print_buf on an empty buffer
    start = strobeCount;
    queuePass(1'b1);
    printBuf();
    repeat (12) tick();
    check("t5_empty_print_strobes", 32'(strobeCount - start), 32'(EOL_N));

    // Reset in the middle of a pass
    for (int i = 0; i < 5; i++) pushByte(8'($urandom_range(0, 255)));
    queuePass(1'b1);
    start = strobeCount;
    printBuf();
    waitStrobes(start + 2, 20);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    expQ.delete();
    modelBuf.delete();
    check("t6_rdy_after_rst", 32'(tx_data_rdy), 0);
    check("t6_level_after_rst", 32'(level), 0);
    check("t6_empty_after_rst", 32'(buf_empty), 1);
    check("t6_data_after_rst", 32'(tx_data), 0);
    repeat (20) tick();
    check("t6_no_more_strobes", 32'(strobeCount - start), 2);
    start = strobeCount;
    queuePass(1'b1);
    printBuf();
    waitDrain(40, 1'b0);
    check("t6_eol_only", 32'(strobeCount - start), 32'(EOL_N));

    // Randomized passes with random UART back-pressure
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) pushByte(8'($urandom_range(0, 255)));
      check("t7_level", 32'(level), 32'(n));
      queuePass(1'b1);
      printBuf();
      waitDrain(600, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_line_buf.md
# tx_line_buf

Line-buffered UART transmit stage that sits directly downstream of the stream-cipher block. It captures every byte the cipher presents on its tx data/ready pair into a FIFO. On the cipher's print-buffer pulse it drains the FIFO to the UART transmitter one byte per handshake, optionally terminating the line with CR LF. It also reports fill level and a sticky overflow flag for the board LEDs.

## Interface
- DEPTH, 32, FIFO entries; power of two, 4..256
- AW, $clog2(DEPTH), pointer width (derived, not overridden)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low; one clock, synchronous active-low reset
- wr_data_rdy  in  1  byte strobe from cipher (L4_tx_data_rdy)
- wr_data  in  8  byte from cipher (L4_tx_data)
- print_buf  in  1  drain request pulse (L4_PrintBuf)
- tx_busy  in  1  UART transmitter busy; high blocks a new byte
- tx_data_rdy  out  1  one-cycle strobe, tx_data valid
- tx_data  out  8  byte to UART transmitter
- buf_empty  out  1  FIFO empty
- buf_full  out  1  FIFO full
- overflow  out  1  sticky: a write was dropped
- level  out  AW+1  current occupancy, 0..DEPTH

## Operation
- States: IDLE (accumulate only), DRAIN (pop and send), GAP (one mandatory idle cycle after every strobe), EOL_CR, EOL_LF.
- Writes are accepted in every state: if wr_data_rdy and (level < DEPTH or a pop occurs this cycle), push wr_data; otherwise drop the byte and set overflow.
- IDLE: print_buf -> DRAIN and clear overflow. Without print_buf, stay.
- DRAIN: if not empty and !tx_busy, pop the head and register it onto tx_data with tx_data_rdy=1 -> GAP. If empty -> EOL_CR (CRLF build) or IDLE (otherwise). If tx_busy is high, hold.
- GAP: always one cycle, then return to the state that issued the strobe's successor (DRAIN, EOL_LF, or IDLE after LF).
- EOL_CR: when !tx_busy, send 0x0D -> GAP -> EOL_LF. EOL_LF: when !tx_busy, send 0x0A -> GAP -> IDLE.
- Bytes written during DRAIN are appended and drained in the same pass. The pass ends only when the FIFO is observed empty in DRAIN.
- print_buf outside IDLE is ignored (no queueing).
- print_buf with an empty FIFO: emits CR LF only (CRLF build), or does nothing and stays IDLE.
- Pointers wrap modulo DEPTH. level is a true count (AW+1 bits), so full is level==DEPTH.

## Timing
- Reset (rst=0 at an edge): state IDLE, pointers 0, level 0, buf_empty 1, buf_full 0, overflow 0, tx_data_rdy 0, tx_data 0x00. Reset mid-drain aborts the pass and discards contents.
- Write at edge N: level, buf_empty, and buf_full reflect it after edge N.
- print_buf sampled at edge N -> DRAIN from N. The first tx_data_rdy is high in cycle N+1→N+2 (registered output) if tx_busy is low at edge N+1.
- Minimum strobe spacing is 2 cycles (strobe, GAP). Strobes are never back-to-back.
- tx_data is held stable until the next strobe. tx_data_rdy is never high for two consecutive cycles.
- Simultaneous push and pop when full: both occur, level unchanged, no overflow.
- Simultaneous print_buf and wr_data_rdy in IDLE: the byte is stored and included in the drain.

## Configuration
- TXBUF_CRLF_EN defined: EOL_CR/EOL_LF are present, and every drain pass ends with 0x0D, 0x0A.
- Undefined: EOL states are removed, DRAIN on empty goes straight to IDLE, and print_buf on an empty FIFO produces no output.

## Structure
- Package tx_line_buf_pkg: state enum (IDLE, DRAIN, GAP, EOL_CR, EOL_LF), constants ASCII_CR=8'h0D and ASCII_LF=8'h0A.
- One sub-module, txb_fifo: DEPTH×8 storage with push/pop, pointers, level/full/empty. The FSM, GAP return tracking, overflow, and output registers live in tx_line_buf.

## Test plan
- Reset, push 0x41,0x42,0x43, print_buf, tx_busy=0 → strobes 0x41,0x42,0x43 (plus 0x0D,0x0A with CRLF) spaced exactly 2 cycles; empty=1 at end, level 0.
- Fill 32 entries, push 0x5A one more → overflow=1, level=32, 0x5A never transmitted; next print_buf clears overflow.
- Drain with tx_busy held high 10 cycles before each byte → no strobe while busy, byte order preserved, no duplicates.
- Push bytes during an active drain → they follow the original bytes in the same pass, and a single CR LF is emitted after the last byte.
- print_buf on an empty FIFO → exactly 0x0D,0x0A (CRLF build) or zero strobes (no CRLF).
- Assert rst=0 mid-drain after 2 of 5 bytes → tx_data_rdy=0, level 0, no further strobes; the next print_buf sends nothing but the EOL.
